vga_sync_porch: RTL and testbench

Conditions the raw sync stage's output before it reaches the VGA pins. The block consumes the raw active-region syncs from the sync-pulse generator and the 3-bit-per-channel pixel data from the pattern stage. It recovers column and row counts from those syncs, generates correctly placed active-low HSync/VSync pulses with front and back porches, and forces RGB to black outside the active 640x480 window. It sits directly downstream of the sync-pulse generator and drives `VGA_HS`, `VGA_VS` and `VGA_R/G/B[2:0]` in `top_VGA`.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_sync_porch_if.sv | 31 +++
 rtl/vga_sync_to_count.sv | 78 +++++++
 rtl/vga_sync_porch.sv | 121 ++++++++++++
 tb/tb_vga_sync_porch.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and a small range helper for the VGA output stage.
package vga_pkg;

  localparam int unsigned VGA_TOTAL_COLS    = 32'd800;
  localparam int unsigned VGA_TOTAL_ROWS    = 32'd525;
  localparam int unsigned VGA_ACTIVE_COLS   = 32'd640;
  localparam int unsigned VGA_ACTIVE_ROWS   = 32'd480;
  localparam int unsigned VGA_FRONT_PORCH_H = 32'd18;
  localparam int unsigned VGA_BACK_PORCH_H  = 32'd50;
  localparam int unsigned VGA_FRONT_PORCH_V = 32'd10;
  localparam int unsigned VGA_BACK_PORCH_V  = 32'd33;
  localparam int unsigned VGA_VIDEO_WIDTH   = 32'd3;

  // Inclusive unsigned range test used for the sync pulse windows.
  function automatic logic in_span(input int unsigned v, input int unsigned lo,
                                   input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_porch_if.sv
// Raw sync/pixel inputs and conditioned VGA pin outputs of the porch stage.
interface vga_sync_porch_if
  import vga_pkg::*;
#(
  parameter int unsigned VIDEO_WIDTH = VGA_VIDEO_WIDTH
);

  logic                   i_HSync;
  logic                   i_VSync;
  logic [VIDEO_WIDTH-1:0] i_Red;
  logic [VIDEO_WIDTH-1:0] i_Grn;
  logic [VIDEO_WIDTH-1:0] i_Blu;
  logic                   o_HSync;
  logic                   o_VSync;
  logic [VIDEO_WIDTH-1:0] o_Red;
  logic [VIDEO_WIDTH-1:0] o_Grn;
  logic [VIDEO_WIDTH-1:0] o_Blu;

  // Upstream side: drives raw syncs and pixels, observes the VGA pins.
  modport master (
    output i_HSync, i_VSync, i_Red, i_Grn, i_Blu,
    input  o_HSync, o_VSync, o_Red, o_Grn, o_Blu
  );

  // Porch stage side.
  modport slave (
    input  i_HSync, i_VSync, i_Red, i_Grn, i_Blu,
    output o_HSync, o_VSync, o_Red, o_Grn, o_Blu
  );

endinterface

// File: rtl/vga_sync_to_count.sv
// Recovers column/row position from the raw VSync rising edge and tracks whether
// a frame start has been seen since reset.
module vga_sync_to_count
  import vga_pkg::*;
#(
  parameter  int unsigned TOTAL_COLS = VGA_TOTAL_COLS,
  parameter  int unsigned TOTAL_ROWS = VGA_TOTAL_ROWS,
  localparam int unsigned COL_W      = $clog2(TOTAL_COLS),
  localparam int unsigned ROW_W      = $clog2(TOTAL_ROWS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hsync_i,
  input  logic             vsync_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             locked_o,
  output logic             hsync_o,
  output logic             vsync_o
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(TOTAL_COLS - 32'd1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TOTAL_ROWS - 32'd1);

  logic             vsync_q;
  logic             hsync_q;
  logic             locked_q, locked_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             frame_start_s;

  assign frame_start_s = vsync_i & ~vsync_q;

  // Next position: a frame start overrides any wrap and re-aligns the counters.
  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    locked_d = locked_q;
    if (frame_start_s) begin
      col_d    = {COL_W{1'b0}};
      row_d    = {ROW_W{1'b0}};
      locked_d = 1'b1;
    end else if (col_q == COL_LAST) begin
      col_d = {COL_W{1'b0}};
      if (row_q == ROW_LAST) begin
        row_d = {ROW_W{1'b0}};
      end else begin
        row_d = row_q + ROW_W'(1);
      end
    end else begin
      col_d = col_q + COL_W'(1);
    end
  end

  // Edge register resets high so a VSync already high at release is not an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vsync_q  <= 1'b1;
      hsync_q  <= 1'b0;
      locked_q <= 1'b0;
      col_q    <= {COL_W{1'b0}};
      row_q    <= {ROW_W{1'b0}};
    end else begin
      vsync_q  <= vsync_i;
      hsync_q  <= hsync_i;
      locked_q <= locked_d;
      col_q    <= col_d;
      row_q    <= row_d;
    end
  end

  assign col_o    = col_q;
  assign row_o    = row_q;
  assign locked_o = locked_q;
  assign hsync_o  = hsync_q;
  assign vsync_o  = vsync_q;

endmodule

// File: rtl/vga_sync_porch.sv
// VGA output conditioning: two-stage pipeline that places active-low sync pulses
// with porches and blanks RGB outside the visible window.
module vga_sync_porch
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL_COLS    = VGA_TOTAL_COLS,
  parameter int unsigned TOTAL_ROWS    = VGA_TOTAL_ROWS,
  parameter int unsigned ACTIVE_COLS   = VGA_ACTIVE_COLS,
  parameter int unsigned ACTIVE_ROWS   = VGA_ACTIVE_ROWS,
  parameter int unsigned FRONT_PORCH_H = VGA_FRONT_PORCH_H,
  parameter int unsigned BACK_PORCH_H  = VGA_BACK_PORCH_H,
  parameter int unsigned FRONT_PORCH_V = VGA_FRONT_PORCH_V,
  parameter int unsigned BACK_PORCH_V  = VGA_BACK_PORCH_V,
  parameter int unsigned VIDEO_WIDTH   = VGA_VIDEO_WIDTH
) (
  input logic              CLK,
  input logic              RST,
  vga_sync_porch_if.slave  vga
);

  localparam int unsigned COL_W    = $clog2(TOTAL_COLS);
  localparam int unsigned ROW_W    = $clog2(TOTAL_ROWS);
  localparam int unsigned HS_FIRST = ACTIVE_COLS + FRONT_PORCH_H;
  localparam int unsigned HS_LAST  = TOTAL_COLS - BACK_PORCH_H - 32'd1;
  localparam int unsigned VS_FIRST = ACTIVE_ROWS + FRONT_PORCH_V;
  localparam int unsigned VS_LAST  = TOTAL_ROWS - BACK_PORCH_V - 32'd1;

  logic [COL_W-1:0]       col_s;
  logic [ROW_W-1:0]       row_s;
  logic                   locked_s;
  logic                   hsync_dly_s;
  logic                   vsync_dly_s;
  logic [VIDEO_WIDTH-1:0] red_q, grn_q, blu_q;
  logic [VIDEO_WIDTH-1:0] red_d2, grn_d2, blu_d2;
  logic [VIDEO_WIDTH-1:0] red_q2, grn_q2, blu_q2;
  logic                   hs_d, vs_d, hs_q, vs_q;
  logic                   visible_s;

  vga_sync_to_count #(
    .TOTAL_COLS (TOTAL_COLS),
    .TOTAL_ROWS (TOTAL_ROWS)
  ) u_count (
    .clk_i    (CLK),
    .rst_i    (RST),
    .hsync_i  (vga.i_HSync),
    .vsync_i  (vga.i_VSync),
    .col_o    (col_s),
    .row_o    (row_s),
    .locked_o (locked_s),
    .hsync_o  (hsync_dly_s),
    .vsync_o  (vsync_dly_s)
  );

  // Delayed raw syncs are kept for downstream alignment checking only.
  logic unused_sync_s;
  assign unused_sync_s = hsync_dly_s ^ vsync_dly_s;

  // Stage 1 pixel delay keeps each pixel beside the counter value of its cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      red_q <= {VIDEO_WIDTH{1'b0}};
      grn_q <= {VIDEO_WIDTH{1'b0}};
      blu_q <= {VIDEO_WIDTH{1'b0}};
    end else begin
      red_q <= vga.i_Red;
      grn_q <= vga.i_Grn;
      blu_q <= vga.i_Blu;
    end
  end

  assign visible_s = (32'(col_s) < ACTIVE_COLS) && (32'(row_s) < ACTIVE_ROWS);

  // Stage 2 decode: idle until locked, then porch-placed syncs and blanking.
  always_comb begin
    hs_d   = 1'b1;
    vs_d   = 1'b1;
    red_d2 = {VIDEO_WIDTH{1'b0}};
    grn_d2 = {VIDEO_WIDTH{1'b0}};
    blu_d2 = {VIDEO_WIDTH{1'b0}};
    if (locked_s) begin
      hs_d = ~in_span(32'(col_s), HS_FIRST, HS_LAST);
      vs_d = ~in_span(32'(row_s), VS_FIRST, VS_LAST);
      if (visible_s) begin
        red_d2 = red_q;
        grn_d2 = grn_q;
        blu_d2 = blu_q;
      end else begin
        red_d2 = {VIDEO_WIDTH{1'b0}};
        grn_d2 = {VIDEO_WIDTH{1'b0}};
        blu_d2 = {VIDEO_WIDTH{1'b0}};
      end
    end else begin
      hs_d = 1'b1;
      vs_d = 1'b1;
    end
  end

  // Output registers drive the VGA pins directly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      red_q2 <= {VIDEO_WIDTH{1'b0}};
      grn_q2 <= {VIDEO_WIDTH{1'b0}};
      blu_q2 <= {VIDEO_WIDTH{1'b0}};
    end else begin
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      red_q2 <= red_d2;
      grn_q2 <= grn_d2;
      blu_q2 <= blu_d2;
    end
  end

  assign vga.o_HSync = hs_q;
  assign vga.o_VSync = vs_q;
  assign vga.o_Red   = red_q2;
  assign vga.o_Grn   = grn_q2;
  assign vga.o_Blu   = blu_q2;

endmodule

// File: tb/tb_vga_sync_porch.sv
// Bench for vga_sync_porch: default horizontal timing, shortened frame height so
// whole frames fit in a short run. A position-based model checks every cycle.
module tb_vga_sync_porch;

  localparam int TC  = 800;
  localparam int TR  = 24;
  localparam int AC  = 640;
  localparam int AR  = 16;
  localparam int FPH = 18;
  localparam int BPH = 50;
  localparam int FPV = 2;
  localparam int BPV = 4;
  localparam logic [10:0] IDLE = 11'b11_000_000_000;
  localparam logic [10:0] PIX5 = 11'b11_101_101_101;

  logic clk;
  logic RST;
  int   checks   = 0;
  int   failures = 0;
  int   gen_col  = 0;
  int   gen_row  = 0;

  vga_sync_porch_if #(.VIDEO_WIDTH(3)) vga ();

  vga_sync_porch #(
    .TOTAL_COLS    (TC),
    .TOTAL_ROWS    (TR),
    .ACTIVE_COLS   (AC),
    .ACTIVE_ROWS   (AR),
    .FRONT_PORCH_H (FPH),
    .BACK_PORCH_H  (BPH),
    .FRONT_PORCH_V (FPV),
    .BACK_PORCH_V  (BPV),
    .VIDEO_WIDTH   (3)
  ) dut (
    .CLK (clk),
    .RST (RST),
    .vga (vga)
  );

  logic [10:0] dut_out;
  assign dut_out = {vga.o_HSync, vga.o_VSync, vga.o_Red, vga.o_Grn, vga.o_Blu};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // One pixel clock of a raw sync stream: syncs high in active cols/rows,
  // pixel 101 on all channels at (0,0), otherwise near-white.
  task automatic step(input bit rst_v, input bit vs_lo);
    @(posedge clk);
    #1;
    RST         = rst_v;
    vga.i_HSync = (gen_col < AC);
    vga.i_VSync = vs_lo ? 1'b0 : (gen_row < AR);
    if (gen_col == 0 && gen_row == 0) begin
      vga.i_Red = 3'b101; vga.i_Grn = 3'b101; vga.i_Blu = 3'b101;
    end else begin
      vga.i_Red = 3'(gen_col % 8); vga.i_Grn = 3'b111; vga.i_Blu = 3'b111;
    end
    gen_col++;
    if (gen_col == TC) begin
      gen_col = 0;
      gen_row = (gen_row + 1) % TR;
    end
  endtask

  // Model: expected output follows from position since the last frame start.
  bit          m_valid  = 1'b0;
  bit          m_prev   = 1'b1;
  bit          m_locked = 1'b0;
  int          m_pos    = 0;
  logic [10:0] s_exp    = IDLE;
  logic [10:0] e_exp    = IDLE;

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        checks++;
        if (dut_out !== e_exp) begin
          failures++;
          $display("FAIL model t=%0t: got %b, expected %b", $time, dut_out, e_exp);
        end
      end
      if (RST) begin
        m_prev = 1'b1; m_locked = 1'b0; m_pos = 0;
        s_exp = IDLE; e_exp = IDLE; m_valid = 1'b1;
      end else begin
        int c, r;
        bit fs, hs, vs, vis;
        e_exp  = s_exp;
        fs     = vga.i_VSync && !m_prev;
        m_prev = vga.i_VSync;
        if (fs) begin
          m_locked = 1'b1;
          m_pos    = 0;
        end else begin
          m_pos = (m_pos + 1) % (TC * TR);
        end
        c   = m_pos % TC;
        r   = m_pos / TC;
        hs  = !(c >= AC + FPH && c < TC - BPH);
        vs  = !(r >= AR + FPV && r < TR - BPV);
        vis = (c < AC) && (r < AR);
        if (!m_locked)
          s_exp = IDLE;
        else if (vis)
          s_exp = {hs, vs, vga.i_Red, vga.i_Grn, vga.i_Blu};
        else
          s_exp = {hs, vs, 9'b0};
      end
    end
  end

  initial begin
    int nonidle, fall1, fall2, hs_low, vs_low, vs_first, blank_bad, active_on;
    bit prev_hs;
    RST = 1'b1;
    vga.i_HSync = 1'b1; vga.i_VSync = 1'b1;
    vga.i_Red = 3'b111; vga.i_Grn = 3'b000; vga.i_Blu = 3'b111;
    nonidle = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      RST = 1'b1;
      vga.i_HSync = 1'($urandom_range(1)); vga.i_VSync = 1'($urandom_range(1));
      vga.i_Red = 3'($urandom); vga.i_Grn = 3'($urandom); vga.i_Blu = 3'($urandom);
      if (dut_out !== IDLE) nonidle++;
    end

    // VSync already high at release: no lock until a genuine rising edge.
    gen_col = 0; gen_row = 15;
    repeat (7200) begin
      step(1'b0, 1'b0);
      if (dut_out !== IDLE) nonidle++;
    end
    step(1'b0, 1'b0);
    if (dut_out !== IDLE) nonidle++;
    chk("idle_before_lock", nonidle, 0);
    step(1'b0, 1'b0);
    chk("idle_one_after_fs", int'(dut_out), int'(IDLE));
    step(1'b0, 1'b0);
    chk("latency_fs_pixel", int'(dut_out), int'(PIX5));

    // One full frame from output position (0,0).
    fall1 = -1; fall2 = -1; hs_low = 0; vs_low = 0; vs_first = -1;
    blank_bad = 0; active_on = 0; prev_hs = 1'b1;
    for (int t = 0; t < TC * TR; t++) begin
      int tc, tr;
      tc = t % TC;
      tr = t / TC;
      if (prev_hs && !dut_out[10]) begin
        if (fall1 < 0) fall1 = t;
        else if (fall2 < 0) fall2 = t;
      end
      prev_hs = dut_out[10];
      if (tr == 0 && !dut_out[10]) hs_low++;
      if (!dut_out[9]) begin
        vs_low++;
        if (vs_first < 0) vs_first = t;
      end
      if ((tc >= AC || tr >= AR) && dut_out[8:0] != 9'd0) blank_bad++;
      if (tc < AC && tr < AR && dut_out[8:0] != 9'd0) active_on++;
      step(1'b0, 1'b0);
    end
    chk("hs_first_fall", fall1, 658);
    chk("hs_period", fall2 - fall1, 800);
    chk("hs_width", hs_low, 92);
    chk("vs_low_cycles", vs_low, 1600);
    chk("vs_first_low", vs_first, 18 * 800);
    chk("blank_nonzero", blank_bad, 0);
    chk("active_nonzero", active_on, AC * AR);

    // Re-sync: rising VSync edge injected at col 300 of row 10.
    for (int k = 0; k < 20000 && !(gen_row == 10 && gen_col == 299); k++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    gen_col = 0; gen_row = 0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("resync_pixel", int'(dut_out), int'(PIX5));
    fall1 = -1; prev_hs = 1'b1;
    for (int t = 0; t < 900; t++) begin
      if (prev_hs && !dut_out[10] && fall1 < 0) fall1 = t;
      prev_hs = dut_out[10];
      step(1'b0, 1'b0);
    end
    chk("resync_hs_fall", fall1, 658);

    // Mid-frame reset at row 12.
    for (int k = 0; k < 20000 && !(gen_row == 12 && gen_col == 0); k++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("idle_after_reset", int'(dut_out), int'(IDLE));
    nonidle = 0;
    for (int k = 0; k < 20000 && !(gen_row == 0 && gen_col == 0); k++) begin
      step(1'b0, 1'b0);
      if (dut_out !== IDLE) nonidle++;
    end
    chk("idle_until_fs", nonidle, 0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("resume_early_idle", int'(dut_out), int'(IDLE));
    step(1'b0, 1'b0);
    chk("resume_pixel", int'(dut_out), int'(PIX5));
    repeat (20) step(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
